// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle: shadow-state update port, snoop request/response and writeback handshake.
interface snoop_responder_if #(
    parameter int unsigned TAG_W    = 12,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned WAYS     = 8
);
    localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr;
    logic [WAY_W-1:0]  upd_way;
    logic [1:0]        upd_mesi;

    logic              snp_valid;
    logic              snp_ready;
    logic [1:0]        snp_op;
    logic [ADDR_W-1:0] snp_addr;

    logic              rsp_valid;
    logic [1:0]        rsp_result;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;

    logic              proto_err;

    modport master (
        output upd_valid, upd_addr, upd_way, upd_mesi,
        output snp_valid, snp_op, snp_addr, wb_ready,
        input  upd_ready, snp_ready, rsp_valid, rsp_result,
        input  wb_valid, wb_addr, proto_err
    );

    modport slave (
        input  upd_valid, upd_addr, upd_way, upd_mesi,
        input  snp_valid, snp_op, snp_addr, wb_ready,
        output upd_ready, snp_ready, rsp_valid, rsp_result,
        output wb_valid, wb_addr, proto_err
    );
endinterface

// File: rtl/snoop_responder.sv
// Snoop responder: shadow tag/MESI array answering bus snoops with HIT/HITM/NOHIT and issuing writebacks.
// Define SNOOP_STATS_EN to add saturating hit_cnt/hitm_cnt/nohit_cnt outputs.
module snoop_responder #(
    parameter int unsigned TAG_W    = 12,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned WAYS     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    snoop_responder_if.slave  bus
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       hitm_cnt,
    output logic [15:0]       nohit_cnt
`endif
);
    localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned SETS   = 1 << INDEX_W;

    localparam logic [1:0] MESI_I    = 2'b00;
    localparam logic [1:0] MESI_S    = 2'b01;
    localparam logic [1:0] MESI_M    = 2'b11;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_RWIM   = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;
    localparam logic [1:0] RES_NOHIT = 2'b00;
    localparam logic [1:0] RES_HIT   = 2'b01;
    localparam logic [1:0] RES_HITM  = 2'b10;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WB} state_t;

    logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
    logic [1:0]         mesi_mem [SETS][WAYS];

    state_t             state;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [WAY_W-1:0]   way_q;
    logic [1:0]         mesi_next_q;
    logic               hit_q;

    logic               upd_fire;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               unused_offset_bits;

    logic [TAG_W-1:0]   set_tag  [WAYS];
    logic [1:0]         set_mesi [WAYS];
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [1:0]         hit_mesi;
    logic [1:0]         res;
    logic [1:0]         mesi_next;
    logic               err;

    assign upd_fire = bus.upd_valid & bus.upd_ready;
    assign upd_idx  = bus.upd_addr[OFFSET_W +: INDEX_W];
    assign upd_tag  = bus.upd_addr[ADDR_W-1 -: TAG_W];
    assign unused_offset_bits = ^{bus.upd_addr[OFFSET_W-1:0], bus.snp_addr[OFFSET_W-1:0]};

    // Snooped set as seen after an update completing on the LOOKUP edge
    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_tag[w]  = tag_mem[idx_q][w];
            set_mesi[w] = mesi_mem[idx_q][w];
            if (upd_fire && (upd_idx == idx_q) && (bus.upd_way == WAY_W'(w))) begin
                set_tag[w]  = upd_tag;
                set_mesi[w] = bus.upd_mesi;
            end
        end
    end

    // Lowest-numbered valid way with a matching tag wins
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_mesi = MESI_I;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && (set_mesi[w] != MESI_I) && (set_tag[w] == tag_q)) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_mesi = set_mesi[w];
            end
        end
    end

    // Snoop result and MESI transition; E/M under INVALIDATE is a protocol error
    always_comb begin
        res       = RES_NOHIT;
        mesi_next = hit_mesi;
        err       = 1'b0;
        if (hit) begin
            case (op_q)
                OP_READ: begin
                    mesi_next = MESI_S;
                    res       = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
                end
                OP_RWIM: begin
                    mesi_next = MESI_I;
                    res       = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
                end
                OP_INVAL: begin
                    if (hit_mesi == MESI_S) begin
                        mesi_next = MESI_I;
                        res       = RES_HIT;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (upd_fire) begin
            tag_mem[upd_idx][bus.upd_way] <= upd_tag;
        end
    end

    // Update port and snoop write never coincide since upd_ready is low in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mesi_mem[s][w] <= MESI_I;
                end
            end
        end else if (upd_fire) begin
            mesi_mem[upd_idx][bus.upd_way] <= bus.upd_mesi;
        end else if ((state == RESP) && hit_q) begin
            mesi_mem[idx_q][way_q] <= mesi_next_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= '0;
            tag_q          <= '0;
            idx_q          <= '0;
            way_q          <= '0;
            mesi_next_q    <= MESI_I;
            hit_q          <= 1'b0;
            bus.snp_ready  <= 1'b1;
            bus.upd_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= RES_NOHIT;
            bus.proto_err  <= 1'b0;
            bus.wb_valid   <= 1'b0;
            bus.wb_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.snp_valid && bus.snp_ready) begin
                        op_q          <= bus.snp_op;
                        tag_q         <= bus.snp_addr[ADDR_W-1 -: TAG_W];
                        idx_q         <= bus.snp_addr[OFFSET_W +: INDEX_W];
                        bus.snp_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    way_q          <= hit_way;
                    mesi_next_q    <= mesi_next;
                    hit_q          <= hit;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_result <= res;
                    bus.proto_err  <= err;
                    bus.upd_ready  <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    bus.rsp_valid  <= 1'b0;
                    bus.rsp_result <= RES_NOHIT;
                    bus.proto_err  <= 1'b0;
                    bus.upd_ready  <= 1'b1;
                    if (bus.rsp_result == RES_HITM) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_addr  <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
                        state        <= WB;
                    end else begin
                        bus.snp_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid  <= 1'b0;
                        bus.snp_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    // Per-result counters, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            hitm_cnt  <= '0;
            nohit_cnt <= '0;
        end else if (state == RESP) begin
            if ((bus.rsp_result == RES_HIT) && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if ((bus.rsp_result == RES_HITM) && (hitm_cnt != 16'hFFFF)) begin
                hitm_cnt <= hitm_cnt + 16'd1;
            end
            if ((bus.rsp_result == RES_NOHIT) && (nohit_cnt != 16'hFFFF)) begin
                nohit_cnt <= nohit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Bus-side snoop agent for the L2 cache. It holds a shadow copy of the tag and MESI state for every set and way, and accepts snoop requests (READ, WRITE, RWIM, INVALIDATE) from other bus masters. For each request it returns a snoop result of HIT, HITM or NOHIT and applies the snoop-induced MESI transition. On HITM it issues a writeback request for the modified line. It is the responding end of the snoop-result path that the cache controller consumes when it issues its own bus operations; the controller keeps the shadow state coherent through the update port.

## Interface
- TAG_W, 12, tag bits
- INDEX_W, 4, set index bits
- OFFSET_W, 6, line offset bits
- WAYS, 8, associativity; way field is clog2(WAYS) bits
- ADDR_W, TAG_W+INDEX_W+OFFSET_W, address width

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  controller writes shadow state for one line
- upd_ready  out  1  update accepted this cycle
- upd_addr  in  ADDR_W  address of the line being updated
- upd_way  in  clog2(WAYS)  target way
- upd_mesi  in  2  new state: I=00, S=01, E=10, M=11
- snp_valid  in  1  snoop request present
- snp_ready  out  1  responder idle and able to accept
- snp_op  in  2  READ=00, WRITE=01, RWIM=10, INVALIDATE=11
- snp_addr  in  ADDR_W  snooped address
- rsp_valid  out  1  one-cycle strobe qualifying rsp_result
- rsp_result  out  2  NOHIT=00, HIT=01, HITM=10
- wb_valid  out  1  writeback request for a modified line
- wb_ready  in  1  writeback accepted
- wb_addr  out  ADDR_W  {tag, index, OFFSET_W'0}
- proto_err  out  1  one-cycle pulse on an illegal snoop/state combination

## Operation
- Storage: WAYS×2^INDEX_W entries, each holding a tag and a 2-bit MESI state. Reset sets every entry to I.
- Update port: an update takes effect at a clock edge where upd_valid and upd_ready are both high. upd_ready=0 only in the RESP state; everywhere else it is 1.
- Hit: lowest-numbered way whose state is not I and whose tag equals snp_addr's tag.
- FSM states: IDLE, LOOKUP, RESP, WB.
  - IDLE: snp_ready=1. snp_valid&&snp_ready latches snp_op and snp_addr, then moves to LOOKUP.
  - LOOKUP: reads the set, resolves hit and way, computes the result and next state, then moves to RESP.
  - RESP: rsp_valid=1 and the entry is written. Moves to WB if the result is HITM, otherwise to IDLE.
  - WB: wb_valid=1 and wb_addr is held stable. Returns to IDLE at the edge where wb_ready=1.
- Transitions (no hit means NOHIT with no change, for every op):
  - READ: M→S with HITM; E→S with HIT; S stays S with HIT.
  - RWIM: M→I with HITM; E→I and S→I with HIT.
  - INVALIDATE: S→I with HIT. If the line is in E or M: NOHIT, no change, proto_err pulses in RESP.
  - WRITE: NOHIT and no change in all states.
- LOOKUP samples the array after any update that completed on or before the LOOKUP edge. Because upd_ready=0 in RESP, the snoop write can never collide with an update.

## Timing
- Reset values: snp_ready=1 (IDLE), upd_ready=1, rsp_valid=0, rsp_result=00, wb_valid=0, wb_addr=0, proto_err=0.
- Acceptance happens at edge T0. rsp_valid is high for the single cycle after edge T1, and the state write occurs at edge T2.
- For NOHIT or HIT, snp_ready returns to 1 after T2, giving a throughput of one snoop per 3 cycles.
- For HITM, wb_valid rises after T2 and is held until wb_ready is sampled high. wb_ready arriving in the first WB cycle gives a minimum of 4 cycles per snoop.
- rsp_result is 00 whenever rsp_valid=0.
- Asserting rst_n low at any point forces IDLE, invalidates all entries, and drops wb_valid and rsp_valid immediately. The in-flight snoop is discarded and produces no response.

## Configuration
- SNOOP_STATS_EN defined: adds output ports hit_cnt, hitm_cnt and nohit_cnt, each 16 bits. Each counter increments in RESP for its own result and saturates at 16'hFFFF. All three reset to 0.
- SNOOP_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Update index 0, way 2, tag 12'h111 to M, then READ snoop of the same line. Required: HITM in the T1 cycle; wb_addr = {12'h111, 4'h0, 6'h0}; entry becomes S; with wb_ready=1, snp_ready=1 again 4 cycles after acceptance.
- Same line in E, RWIM snoop. Required: HIT, entry becomes I, no wb_valid; a repeated RWIM gives NOHIT.
- Ways 0 through 7 filled in S with tags 0–7, then INVALIDATE of tag 5. Required: HIT, only way 5 becomes I; a READ of tag 5 then returns NOHIT.
- INVALIDATE of a line in M. Required: NOHIT, proto_err pulses once, line stays M.
- HITM with wb_ready held 0 for 5 cycles. Required: wb_valid and wb_addr stay stable, snp_ready stays 0; upd_ready is 0 only during RESP.
- rst_n pulsed low during WB. Required: wb_valid drops immediately, all entries read NOHIT afterwards, and (with SNOOP_STATS_EN) all counters read 0.
